// File: rtl/instruction_fetch_unit.sv
// uDLX fetch stage: PC, single-outstanding imem read handshake, instruction
// register with a one-entry skid buffer, and redirect handling with in-flight discard.
module instruction_fetch_unit #(
    parameter int PC_WIDTH = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_in,
    input  logic                         redirect_in,
    input  logic [PC_WIDTH-1:0]          redirect_pc_in,
    output logic                         imem_req_out,
    output logic [PC_WIDTH-1:0]          imem_addr_out,
    input  logic                         imem_ack_in,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic                         instruction_valid_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_t                         state, state_n;
    logic [PC_WIDTH-1:0]            pc, pc_n;
    logic [PC_WIDTH-1:0]            addr_q, addr_n;
    logic                           vld_p1, vld_p1_n;
    logic [INSTRUCTION_WIDTH-1:0]   ir_data_p1, ir_data_n;
    logic [PC_WIDTH-1:0]            ir_pc_p1, ir_pc_n;
    logic                           skid_vld, skid_vld_n;
    logic [INSTRUCTION_WIDTH-1:0]   skid_data, skid_data_n;
    logic [PC_WIDTH-1:0]            skid_pc, skid_pc_n;
    logic                           ack_fetch;
    logic                           consume;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        vld_p1_n    = vld_p1;
        ir_data_n   = ir_data_p1;
        ir_pc_n     = ir_pc_p1;
        skid_vld_n  = skid_vld;
        skid_data_n = skid_data;
        skid_pc_n   = skid_pc;
        ack_fetch   = imem_ack_in && (state == FETCH);
        consume     = vld_p1 && !stall_in;

        if (redirect_in) begin
            vld_p1_n   = 1'b0;
            skid_vld_n = 1'b0;
            pc_n       = redirect_pc_in & ALIGN_MASK;
            // An outstanding read must still complete; its word is thrown away.
            case (state)
                IDLE:    state_n = FETCH;
                default: state_n = imem_ack_in ? IDLE : DISCARD;
            endcase
        end else begin
            if (ack_fetch) begin
                pc_n = pc + PC_STEP;
            end

            if (consume && skid_vld) begin
                vld_p1_n    = 1'b1;
                ir_data_n   = skid_data;
                ir_pc_n     = skid_pc;
                skid_vld_n  = ack_fetch;
                skid_data_n = imem_data_in;
                skid_pc_n   = pc;
            end else if (consume || !vld_p1) begin
                vld_p1_n  = ack_fetch;
                ir_data_n = imem_data_in;
                ir_pc_n   = pc;
            end else if (ack_fetch) begin
                skid_vld_n  = 1'b1;
                skid_data_n = imem_data_in;
                skid_pc_n   = pc;
            end

            // A new request is only issued when the returned word has somewhere to go.
            case (state)
                IDLE:    state_n = skid_vld_n ? IDLE : FETCH;
                FETCH:   if (imem_ack_in) state_n = skid_vld_n ? IDLE : FETCH;
                DISCARD: if (imem_ack_in) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        // Address is frozen for the whole life of an outstanding request.
        addr_n = (state != IDLE && !imem_ack_in) ? addr_q : pc_n;
    end

    // Stage p1: control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            addr_q   <= addr_n;
            vld_p1   <= vld_p1_n;
            skid_vld <= skid_vld_n;
        end
    end

    // Stage p1: data registers, qualified by vld_p1 / skid_vld
    always_ff @(posedge clk) begin
        ir_data_p1 <= ir_data_n;
        ir_pc_p1   <= ir_pc_n;
        skid_data  <= skid_data_n;
        skid_pc    <= skid_pc_n;
    end

    assign imem_req_out          = (state != IDLE);
    assign imem_addr_out         = addr_q;
    assign instruction_valid_out = vld_p1;
    assign instruction_out       = vld_p1 ? ir_data_p1 : '0;
    assign pc_out                = vld_p1 ? ir_pc_p1 : '0;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the uDLX pipeline: holds the program counter, issues word reads to instruction memory over a req/ack handshake (one outstanding request, variable latency), and presents fetched instruction words plus their address to the instruction decoder. Provides a one-entry skid buffer so decode stalls never lose a returned word. Handles control-flow redirects from execute, including discarding an in-flight fetch. Bubbles are emitted as the all-zero word, which decode treats as NOP.

## Interface
- PC_WIDTH, 32, byte-address width of PC and memory address
- INSTRUCTION_WIDTH, 32, instruction word width
- RESET_PC, 0, first fetch address after reset (word-aligned)

- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall_in  input  1  decode cannot accept; hold instruction_out
- redirect_in  input  1  taken branch/jump; flush and refetch
- redirect_pc_in  input  PC_WIDTH  redirect target; bits [1:0] ignored (forced 0)
- imem_req_out  output  1  read request
- imem_addr_out  output  PC_WIDTH  read address, stable while req high
- imem_ack_in  input  1  read complete; imem_data_in valid this cycle
- imem_data_in  input  INSTRUCTION_WIDTH  returned word
- instruction_out  output  INSTRUCTION_WIDTH  word to decoder; 0 when not valid
- pc_out  output  PC_WIDTH  address of instruction_out; 0 when not valid
- instruction_valid_out  output  1  instruction_out holds a real instruction

## Operation
- Registers: pc (next fetch address), IR (instruction_out/pc_out/valid), skid (word, address, valid), state.
- States: IDLE (no request outstanding), FETCH (imem_req_out=1, awaiting ack), DISCARD (request outstanding, result to be dropped).
- Issue rule: from IDLE, or from FETCH on the ack cycle, raise/keep req next cycle iff skid will be empty and state is not DISCARD. imem_addr_out = pc.
- Once raised, req stays high with constant address until ack (protocol rule, also across redirect). Ack outside FETCH/DISCARD is ignored.
- On ack in FETCH: pc <= pc+4 (modulo 2^PC_WIDTH, 0xFFFFFFFC wraps to 0). Word loads IR if IR is empty or is consumed this cycle (valid && !stall_in), else loads skid.
- IR consumed (valid && !stall_in): IR <= skid if skid valid (skid empties), else IR <= ack data if present, else IR invalid (outputs forced 0).
- Redirect (highest priority, overrides stall_in): IR and skid invalidated, pc <= {redirect_pc_in[PC_WIDTH-1:2],2'b00}. If request outstanding and no ack this cycle -> DISCARD; if ack this cycle, data dropped -> IDLE. Redirect in DISCARD updates pc, stays DISCARD.
- DISCARD: on ack, drop data, -> IDLE; pc unchanged.
- Reset: state IDLE, pc=RESET_PC, imem_req_out=0, imem_addr_out=RESET_PC, instruction_out=0, pc_out=0, instruction_valid_out=0, skid invalid. Reset mid-request abandons it; memory is reset by the same rst.

## Timing
- First req: first cycle after rst deasserts.
- Ack in cycle N (FETCH) -> instruction_valid_out in cycle N+1.
- Zero-wait memory (ack same cycle as req): req continuously high, one instruction per cycle, address +4 each cycle.
- Redirect in cycle N with no outstanding request: req to target in cycle N+1; valid=0 in N+1.
- Stall with IR valid: at most one further word accepted (skid); req low from cycle after skid fills until skid drains.
- Outputs registered; imem_req_out/imem_addr_out registered, no combinational path from ack or stall_in.

## Test plan
- Reset, zero-wait memory, mem[a]=0x20000000|a: req in cycle 1, valid from cycle 2, pc_out 0,4,8,... one per cycle, instruction_out matches.
- Stall 3 cycles mid-stream: IR frozen, skid takes exactly one word, req low until release; sequence after release gapless, no duplicate/lost word.
- Memory latency 3, redirect to 0x100 one cycle after req at 0x8: req/addr 0x8 held until ack, data dropped, next req addr 0x100, no valid output of 0x8 word.
- Redirect same cycle as ack while stalled with skid full: next cycle valid=0, instruction_out=0, pc_out=0, fetch at target.
- redirect_pc_in=0x102 -> fetch 0x100; redirect to 0xFFFFFFFC -> following fetch 0x00000000.
- rst asserted while req outstanding: next cycle req=0, all outputs at reset values; a late ack is ignored; fetch restarts at RESET_PC.
